// File: rtl/stage_decode_sb.sv
// Decode stage: operand fetch from a small register file, immediate extraction
// and a busy-bit scoreboard that stalls fetch on RAW/WAW hazards.
module stage_decode_sb #(
    parameter int XLEN      = 32,
    parameter int NREGS     = 32,
    parameter int BYPASS_EN = 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     pc_i,
    input  logic [31:0]     instr,
    input  logic            flush,
    input  logic            wr_en,
    input  logic [4:0]      wr_rd,
    input  logic [XLEN-1:0] wr_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     pc_o,
    output logic [6:0]      opcode,
    output logic [2:0]      funct3,
    output logic [6:0]      funct7,
    output logic [4:0]      rd,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic [XLEN-1:0] imm_se,
    output logic            rd_we
);
    localparam int AW = $clog2(NREGS);

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LD   = 7'b0000011;
    localparam logic [6:0] OP_ST   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_AUI  = 7'b0010111;

    logic [XLEN-1:0] rf_q [NREGS];
    logic [XLEN-1:0] rf_d [NREGS];
    logic [NREGS-1:0] busy_q, busy_d;

    logic            out_valid_q, out_valid_d;
    logic [31:0]     pc_q, pc_d;
    logic [6:0]      opcode_q, opcode_d;
    logic [2:0]      funct3_q, funct3_d;
    logic [6:0]      funct7_q, funct7_d;
    logic [4:0]      rd_q, rd_d;
    logic [XLEN-1:0] rs1_q, rs1_d;
    logic [XLEN-1:0] rs2_q, rs2_d;
    logic [XLEN-1:0] imm_q, imm_d;
    logic            rd_we_q, rd_we_d;

    logic [6:0] in_op;
    logic [4:0] in_rs1, in_rs2, in_rd;
    logic       use1, use2, writer;
    logic       hazard, accept, out_hs;
    logic signed [31:0] imm32;

    assign in_op  = instr[6:0];
    assign in_rd  = instr[11:7];
    assign in_rs1 = instr[19:15];
    assign in_rs2 = instr[24:20];

    function automatic logic legal(input logic [4:0] idx);
        return (idx != 5'd0) && (NREGS == 32 || !idx[4]);
    endfunction

    function automatic logic byp_hit(input logic [4:0] idx);
        return (BYPASS_EN != 0) && wr_en && (wr_rd == idx);
    endfunction

    function automatic logic [XLEN-1:0] rd_port(input logic [4:0] idx);
        if (!legal(idx)) return '0;
        if (byp_hit(idx)) return wr_data;
        return rf_q[idx[AW-1:0]];
    endfunction

    // A write landing this cycle releases the busy bit early when it is forwarded.
    function automatic logic src_busy(input logic [4:0] idx);
        logic sb;
        logic held;
        sb   = busy_q[idx[AW-1:0]] && !byp_hit(idx);
        held = out_valid_q && rd_we_q && (rd_q == idx);
        return legal(idx) && (sb || held);
    endfunction

    always_comb begin
        use1   = 1'b0;
        use2   = 1'b0;
        writer = 1'b0;
        unique case (in_op)
            OP_R: begin
                use1   = 1'b1;
                use2   = 1'b1;
                writer = 1'b1;
            end
            OP_I, OP_LD, OP_JALR: begin
                use1   = 1'b1;
                writer = 1'b1;
            end
            OP_ST, OP_BR: begin
                use1 = 1'b1;
                use2 = 1'b1;
            end
            OP_JAL, OP_LUI, OP_AUI: writer = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        unique case (in_op)
            OP_ST:  imm32 = 32'($signed({instr[31:25], instr[11:7]}));
            OP_BR:  imm32 = 32'($signed({instr[31], instr[7], instr[30:25],
                                         instr[11:8], 1'b0}));
            OP_LUI, OP_AUI: imm32 = {instr[31:12], 12'b0};
            OP_JAL: imm32 = 32'($signed({instr[31], instr[19:12], instr[20],
                                         instr[30:21], 1'b0}));
            default: imm32 = 32'($signed(instr[31:20]));
        endcase
    end

    assign hazard = (use1 && src_busy(in_rs1))
                  || (use2 && src_busy(in_rs2))
                  || (writer && legal(in_rd) && busy_q[in_rd[AW-1:0]]);
    assign in_ready = (!out_valid_q || out_ready) && !hazard && !flush;
    assign accept   = in_valid && in_ready;
    assign out_hs   = out_valid_q && out_ready && !flush;

    // Set is applied after clear so a same-cycle set/clear leaves the bit set.
    always_comb begin
        rf_d   = rf_q;
        busy_d = busy_q;
        for (int i = 1; i < NREGS; i++) begin
            if (wr_en && wr_rd == 5'(i)) begin
                rf_d[i]   = wr_data;
                busy_d[i] = 1'b0;
            end
        end
        if (out_hs && rd_we_q && legal(rd_q))
            busy_d[rd_q[AW-1:0]] = 1'b1;
    end

    always_comb begin
        pc_d     = pc_q;
        opcode_d = opcode_q;
        funct3_d = funct3_q;
        funct7_d = funct7_q;
        rd_d     = rd_q;
        rs1_d    = rs1_q;
        rs2_d    = rs2_q;
        imm_d    = imm_q;
        rd_we_d  = rd_we_q;
        if (accept) begin
            pc_d     = pc_i;
            opcode_d = in_op;
            funct3_d = instr[14:12];
            funct7_d = instr[31:25];
            rd_d     = in_rd;
            rs1_d    = rd_port(in_rs1);
            rs2_d    = rd_port(in_rs2);
            imm_d    = XLEN'(imm32);
            rd_we_d  = writer && (in_rd != 5'd0);
        end
        if (flush)       out_valid_d = 1'b0;
        else if (accept) out_valid_d = 1'b1;
        else if (out_hs) out_valid_d = 1'b0;
        else             out_valid_d = out_valid_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
            busy_q      <= '0;
            out_valid_q <= 1'b0;
            pc_q        <= '0;
            opcode_q    <= '0;
            funct3_q    <= '0;
            funct7_q    <= '0;
            rd_q        <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            imm_q       <= '0;
            rd_we_q     <= 1'b0;
        end else begin
            rf_q        <= rf_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            pc_q        <= pc_d;
            opcode_q    <= opcode_d;
            funct3_q    <= funct3_d;
            funct7_q    <= funct7_d;
            rd_q        <= rd_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            imm_q       <= imm_d;
            rd_we_q     <= rd_we_d;
        end
    end

    assign out_valid = out_valid_q;
    assign pc_o      = pc_q;
    assign opcode    = opcode_q;
    assign funct3    = funct3_q;
    assign funct7    = funct7_q;
    assign rd        = rd_q;
    assign rs1_data  = rs1_q;
    assign rs2_data  = rs2_q;
    assign imm_se    = imm_q;
    assign rd_we     = rd_we_q;
endmodule

// File: tb/tb_stage_decode_sb.sv
// Bench for stage_decode_sb: directed scenarios plus random traffic checked
// every cycle against a behavioural register-file/scoreboard model.
module tb_stage_decode_sb;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid, in_ready, flush, wr_en, out_valid, out_ready, rd_we;
    logic [31:0] pc_i, instr, wr_data, pc_o, rs1_data, rs2_data, imm_se;
    logic [4:0]  wr_rd, rd;
    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    stage_decode_sb #(.XLEN(32), .NREGS(32), .BYPASS_EN(1)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .pc_i(pc_i), .instr(instr), .flush(flush),
        .wr_en(wr_en), .wr_rd(wr_rd), .wr_data(wr_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .pc_o(pc_o), .opcode(opcode), .funct3(funct3),
        .funct7(funct7), .rd(rd),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .imm_se(imm_se), .rd_we(rd_we)
    );

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_reg [32];
    bit          m_busy [32];
    bit          h_valid;
    logic [31:0] h_pc, h_instr, h_rs1, h_rs2;

    function automatic bit f_writer(input logic [6:0] op);
        return op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b1101111,
                          7'b1100111, 7'b0110111, 7'b0010111};
    endfunction

    function automatic bit f_use1(input logic [6:0] op);
        return op inside {7'b0110011, 7'b0010011, 7'b0000011,
                          7'b0100011, 7'b1100011, 7'b1100111};
    endfunction

    function automatic bit f_use2(input logic [6:0] op);
        return op inside {7'b0110011, 7'b0100011, 7'b1100011};
    endfunction

    function automatic logic [31:0] exp_imm(input logic [31:0] w);
        logic signed [31:0] v;
        case (w[6:0])
            7'b0100011: v = 32'($signed({w[31:25], w[11:7]}));
            7'b1100011: v = 32'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0}));
            7'b0110111, 7'b0010111: v = {w[31:12], 12'b0};
            7'b1101111: v = 32'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0}));
            default: v = 32'($signed(w[31:20]));
        endcase
        return v;
    endfunction

    function automatic bit h_rdwe();
        return f_writer(h_instr[6:0]) && h_instr[11:7] != 5'd0;
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] idx);
        if (idx == 5'd0) return 32'd0;
        if (wr_en && wr_rd == idx) return wr_data;
        return m_reg[idx];
    endfunction

    function automatic bit m_blocked(input logic [4:0] idx);
        bit sb, held;
        sb   = m_busy[idx] && !(wr_en && wr_rd == idx);
        held = h_valid && h_rdwe() && h_instr[11:7] == idx;
        return idx != 5'd0 && (sb || held);
    endfunction

    function automatic bit m_ready();
        bit hz;
        logic [6:0] op;
        op = instr[6:0];
        hz = (f_use1(op) && m_blocked(instr[19:15]))
          || (f_use2(op) && m_blocked(instr[24:20]))
          || (f_writer(op) && instr[11:7] != 5'd0 && m_busy[instr[11:7]]);
        return (!h_valid || out_ready) && !flush && !hz;
    endfunction

    task automatic m_clear();
        for (int i = 0; i < 32; i++) begin
            m_reg[i]  = 32'd0;
            m_busy[i] = 1'b0;
        end
        h_valid = 1'b0;
        h_pc    = 32'd0;
        h_instr = 32'd0;
        h_rs1   = 32'd0;
        h_rs2   = 32'd0;
    endtask

    initial begin
        m_clear();
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                m_clear();
            end else begin
                bit acc, hs;
                logic [4:0] hrd;
                acc = in_valid && m_ready();
                hs  = h_valid && out_ready && !flush;
                hrd = h_instr[11:7];
                if (acc) begin
                    h_pc    = pc_i;
                    h_rs1   = m_read(instr[19:15]);
                    h_rs2   = m_read(instr[24:20]);
                end
                if (wr_en && wr_rd != 5'd0) begin
                    m_reg[wr_rd]  = wr_data;
                    m_busy[wr_rd] = 1'b0;
                end
                if (hs && f_writer(h_instr[6:0]) && hrd != 5'd0)
                    m_busy[hrd] = 1'b1;
                if (acc) h_instr = instr;
                if (flush)    h_valid = 1'b0;
                else if (acc) h_valid = 1'b1;
                else if (hs)  h_valid = 1'b0;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            chk("out_valid", out_valid, h_valid);
            chk("in_ready", in_ready, m_ready());
            chk("pc_o", pc_o, h_pc);
            chk("opcode", opcode, h_instr[6:0]);
            chk("funct3", funct3, h_instr[14:12]);
            chk("funct7", funct7, h_instr[31:25]);
            chk("rd", rd, h_instr[11:7]);
            chk("rd_we", rd_we, h_rdwe());
            chk("rs1_data", rs1_data, h_rs1);
            chk("rs2_data", rs2_data, h_rs2);
            chk("imm_se", imm_se, exp_imm(h_instr));
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic [31:0] enc_r(input logic [4:0] d, s1, s2);
        return {7'b0, s2, s1, 3'b000, d, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [4:0] d, s1,
                                          input logic [11:0] im);
        return {im, s1, 3'b000, d, 7'b0010011};
    endfunction

    function automatic logic [31:0] enc_sw(input logic [11:0] im);
        return {im[11:5], 5'd0, 5'd0, 3'b010, im[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] o);
        return {o[12], o[10:5], 5'd0, 5'd0, 3'b000, o[4:1], o[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_j(input logic [4:0] d,
                                          input logic [20:0] o);
        return {o[20], o[10:1], o[11], o[19:12], d, 7'b1101111};
    endfunction

    logic [6:0] ops [11] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                             7'b1100011, 7'b1100111, 7'b1101111, 7'b0110111,
                             7'b0010111, 7'b0001111, 7'b1110011};

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        w = $urandom;
        if ($urandom_range(0, 11) == 11) w[6:0] = 7'($urandom);
        else w[6:0] = ops[$urandom_range(0, 10)];
        w[11:7]  = 5'($urandom_range(0, 7));
        w[19:15] = 5'($urandom_range(0, 7));
        w[24:20] = 5'($urandom_range(0, 7));
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        in_valid = 0; out_ready = 0; flush = 0; wr_en = 0;
        wr_rd = 0; wr_data = 0; pc_i = 0; instr = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_ready", in_ready, 1'b1);
        chk("rst_rdwe", rd_we, 1'b0);
        reset_n = 1;
        tick();

        // write x5, then ADD x6,x5,x5
        wr_en = 1; wr_rd = 5; wr_data = 32'h1234;
        tick();
        wr_en = 0;
        in_valid = 1; instr = enc_r(6, 5, 5); pc_i = 32'h100; out_ready = 1;
        #1 chk("add_ready", in_ready, 1'b1);
        tick();
        in_valid = 0;
        chk("add_valid", out_valid, 1'b1);
        chk("add_rs1", rs1_data, 32'h1234);
        chk("add_rs2", rs2_data, 32'h1234);
        chk("add_rd", rd, 5'd6);
        chk("add_rdwe", rd_we, 1'b1);
        tick();
        wr_en = 1; wr_rd = 6; wr_data = 32'h66;
        tick();
        wr_en = 0;

        // immediates
        in_valid = 1; instr = 32'hFFC0A383; pc_i = 32'h104;
        tick();
        chk("lw_imm", imm_se, 32'hFFFFFFFC);
        chk("lw_rd", rd, 5'd7);
        instr = enc_b(13'h1FF8);
        tick();
        chk("beq_imm", imm_se, 32'hFFFFFFF8);
        instr = enc_j(5'd0, 21'h800);
        tick();
        chk("jal_imm", imm_se, 32'h00000800);
        in_valid = 0;
        tick();

        // load-use stall released by forwarded writeback
        in_valid = 1; instr = enc_r(8, 7, 0);
        #1 chk("stall_a", in_ready, 1'b0);
        tick();
        chk("stall_b", in_ready, 1'b0);
        wr_en = 1; wr_rd = 7; wr_data = 32'hAA;
        #1 chk("byp_ready", in_ready, 1'b1);
        tick();
        wr_en = 0; in_valid = 0;
        chk("byp_valid", out_valid, 1'b1);
        chk("byp_rs1", rs1_data, 32'hAA);
        tick();
        wr_en = 1; wr_rd = 8; wr_data = 32'h88;
        tick();
        wr_en = 0;

        // backpressure hold then streaming
        in_valid = 1; instr = enc_sw(12'h010); pc_i = 32'h200;
        tick();
        out_ready = 0; instr = enc_sw(12'h020); pc_i = 32'h204;
        repeat (3) begin
            #1;
            chk("hold_ready", in_ready, 1'b0);
            chk("hold_pc", pc_o, 32'h200);
            tick();
        end
        out_ready = 1;
        for (int k = 1; k <= 3; k++) begin
            pc_i = 32'h200 + 32'(4 * k);
            tick();
            chk("stream_pc", pc_o, 32'h200 + 32'(4 * k));
        end

        // flush of a held instruction keeps the scoreboard
        instr = enc_i(9, 0, 12'h001); pc_i = 32'h300;
        tick();
        instr = enc_sw(12'h004); pc_i = 32'h304;
        tick();
        in_valid = 0; flush = 1;
        #1 chk("flush_ready", in_ready, 1'b0);
        tick();
        flush = 0;
        chk("flush_valid", out_valid, 1'b0);
        in_valid = 1; instr = enc_r(10, 9, 0); pc_i = 32'h308;
        #1 chk("busy_kept", in_ready, 1'b0);
        tick();
        chk("busy_kept2", in_ready, 1'b0);

        // reset during a stall
        reset_n = 0;
        #1;
        chk("rst2_valid", out_valid, 1'b0);
        chk("rst2_ready", in_ready, 1'b1);
        chk("rst2_pc", pc_o, 32'd0);
        tick();
        reset_n = 1;
        tick();
        chk("rst2_acc", out_valid, 1'b1);
        chk("rst2_rd", rd, 5'd10);
        chk("rst2_pc2", pc_o, 32'h308);

        // writes to x0 are ignored, even when forwarded
        instr = enc_r(11, 0, 0); pc_i = 32'h30C;
        wr_en = 1; wr_rd = 0; wr_data = 32'hDEAD;
        tick();
        wr_en = 0; in_valid = 0;
        chk("x0_rs1", rs1_data, 32'd0);
        chk("x0_rs2", rs2_data, 32'd0);
        tick();

        // random traffic
        repeat (3000) begin
            in_valid  = $urandom_range(0, 3) != 0;
            out_ready = $urandom_range(0, 3) != 0;
            flush     = $urandom_range(0, 19) == 0;
            wr_en     = $urandom_range(0, 2) == 0;
            wr_rd     = 5'($urandom_range(0, 7));
            wr_data   = $urandom;
            pc_i      = $urandom;
            instr     = rand_instr();
            tick();
        end
        in_valid = 0; flush = 0; wr_en = 0;
        tick();
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
